imm_extender_pipe: RTL and testbench
====================================

Name: imm_extender_pipe

Overview:
Parametrised, registered immediate extender for the next-generation datapath. It widens an IN_W-bit instruction immediate to OUT_W bits in one of four modes: zero, sign, upper-placement, or prefix-concatenate. Prefix-concatenate combines two consecutive immediates into one wide constant. The block sits between decode and the ALU operand mux, with a valid/ready handshake on both sides and one output register stage.

Parameters:
IN_W, 8, immediate input width (>=2)
OUT_W, 16, extended output width (must be > IN_W)
PREFIX_TIMEOUT, 15, cycles a pending prefix survives without a new accept (used only with optional feature)

Ports:
CLK  input  1  clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
InValid  input  1  upstream immediate valid
InReady  output  1  block can accept this cycle
Immediate  input  IN_W  raw immediate
Mode  input  2  0=zero-ext, 1=sign-ext, 2=upper, 3=prefix
OutValid  output  1  Out holds a valid result
OutReady  input  1  downstream accepts Out
Out  output  OUT_W  extended result
PrefixPending  output  1  a prefix is stored and awaiting its partner

Behaviour:
- Reset (sampled on CLK while Reset=1): OutValid=0, Out=0, PrefixPending=0, prefix register=0, timeout counter=0. Reset overrides any simultaneous accept.
- InReady = !OutValid || OutReady (combinational). Accept = InValid && InReady.
- Output register: on accept of a non-prefix Mode, Out/OutValid load next edge (latency 1 cycle). If OutValid && OutReady with no accept, OutValid->0 and Out holds its last value. Out holds stable while OutValid && !OutReady.
- Prefix register width P = OUT_W-IN_W.
- Mode 0: Out = {P zeros, Immediate}.
- Mode 1: Out = {P copies of Immediate[IN_W-1], Immediate}.
- Mode 2: Out = ({P zeros, Immediate} << P), truncated to OUT_W. Low P bits are 0. If OUT_W < 2*IN_W, the top Immediate bits are discarded.
- Mode 3 (prefix): stores Immediate into the prefix register, using the low min(IN_W,P) bits zero-extended to P. Sets PrefixPending=1. Produces no output; OutValid is unaffected except by normal draining. Prefix accept is allowed even while Out is full if InReady=1.
- States: IDLE (PrefixPending=0) and PREFIXED (PrefixPending=1).
  - IDLE + accept Mode3 -> PREFIXED.
  - PREFIXED + accept Mode3 -> PREFIXED; the prefix register is overwritten (last prefix wins).
  - PREFIXED + accept Mode0/1/2 -> Out = {prefix, Immediate}; the Mode value is ignored for that word. Goes to IDLE and clears the prefix register.
- No accept: state holds.
- Reset mid-prefix: the prefix is discarded; the next word is extended per its own Mode.

Optional Feature:
Macro EXT_PREFIX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to PREFIXED and on every prefix accept.
  - It increments each cycle in PREFIXED with no accept.
  - When it reaches PREFIX_TIMEOUT, the next edge returns to IDLE and drops the prefix. The next word is then extended normally.
  - The counter saturates and never wraps.
- Not defined: the counter is absent and a prefix persists indefinitely until consumed or Reset.

Test Plan:
1. Reset 2 cycles, then Mode0 Imm=0x07 with OutReady=1 -> next cycle OutValid=1, Out=0x0007. Mode1 Imm=0x07 -> Out=0x0007.
2. Mode0 Imm=0xF7 -> Out=0x00F7. Mode1 Imm=0xF7 -> Out=0xFFF7. Mode2 Imm=0xF7 -> Out=0xF700.
3. Mode3 Imm=0x12 -> PrefixPending=1, OutValid stays 0. Then Mode1 Imm=0x80 -> Out=0x1280 (not sign-extended), PrefixPending=0.
4. Backpressure: OutReady=0, accept Imm=0x05 -> OutValid=1, InReady=0. Hold InValid with Imm=0x06 for 3 cycles -> Out stays 0x0005. Raise OutReady -> Out=0x0006 one cycle later, no word lost or duplicated.
5. Mode3 0x11 then Mode3 0x22 then Mode0 0x33 -> Out=0x2233. Mode3 0x44 then Reset then Mode1 0x80 -> Out=0xFF80.
6. With EXT_PREFIX_TIMEOUT_EN, PREFIX_TIMEOUT=15: Mode3 0xAB, idle 16 cycles -> PrefixPending=0. Then Mode0 0x01 -> Out=0x0001. Without the macro, the same stimulus gives Out=0xAB01.

Source files
------------

// File: rtl/imm_extender_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_extender_pipe_if
//   Handshake and data bundle for the registered immediate extender.
//   The upstream and downstream sides are grouped in one interface, so a single
//   producer/consumer (for example a decode stage model) drives the master side.
//
// Parameters
//   IN_W  : raw immediate width
//   OUT_W : extended result width
//
// Signals
//   InValid       : upstream immediate valid             (master -> slave)
//   InReady       : extender can accept this cycle       (slave  -> master)
//   Immediate     : raw immediate, IN_W bits             (master -> slave)
//   Mode          : 0 zero, 1 sign, 2 upper, 3 prefix    (master -> slave)
//   OutValid      : Out holds a valid result             (slave  -> master)
//   OutReady      : downstream accepts Out               (master -> slave)
//   Out           : extended result, OUT_W bits          (slave  -> master)
//   PrefixPending : a prefix is stored, awaiting partner (slave  -> master)
// -----------------------------------------------------------------------------
interface imm_extender_pipe_if #(
   parameter int IN_W  = 8,
   parameter int OUT_W = 16
);
   logic             InValid;
   logic             InReady;
   logic [IN_W-1:0]  Immediate;
   logic [1:0]       Mode;
   logic             OutValid;
   logic             OutReady;
   logic [OUT_W-1:0] Out;
   logic             PrefixPending;

   modport master (
      output InValid, Immediate, Mode, OutReady,
      input  InReady, OutValid, Out, PrefixPending
   );

   modport slave (
      input  InValid, Immediate, Mode, OutReady,
      output InReady, OutValid, Out, PrefixPending
   );
endinterface

// File: rtl/imm_extender_pipe.sv
// -----------------------------------------------------------------------------
// imm_extender_pipe
//   Registered immediate extender between decode and the ALU operand mux.
//   Widens an IN_W-bit immediate to OUT_W bits (zero, sign, upper placement)
//   or, in prefix mode, stores the immediate so that the next word is emitted
//   as {prefix, immediate}. One output register stage, valid/ready on both
//   sides, InReady = !OutValid || OutReady.
//
// Parameters
//   IN_W           : immediate input width (>= 2)
//   OUT_W          : extended output width (> IN_W)
//   PREFIX_TIMEOUT : idle cycles a pending prefix survives (timeout build only)
//
// Ports
//   CLK   : clock, all state on the rising edge
//   Reset : synchronous, active-high reset
//   bus   : imm_extender_pipe_if.slave (handshakes, Immediate, Mode, Out,
//           PrefixPending)
//
// Build option
//   EXT_PREFIX_TIMEOUT_EN : when defined, a pending prefix is dropped after
//                           PREFIX_TIMEOUT idle cycles; otherwise it persists
//                           until consumed or Reset.
// -----------------------------------------------------------------------------
module imm_extender_pipe #(
   parameter int IN_W           = 8,
   parameter int OUT_W          = 16,
   parameter int PREFIX_TIMEOUT = 15
) (
   input  logic                CLK,
   input  logic                Reset,
   imm_extender_pipe_if.slave  bus
);

   // Prefix register width, and how many immediate bits fit into it.
   localparam int P  = OUT_W - IN_W;
   localparam int PW = (IN_W < P) ? IN_W : P;

   if (IN_W < 2 || OUT_W <= IN_W || PREFIX_TIMEOUT < 1) begin : g_bad_params
      $error("imm_extender_pipe: illegal parameters IN_W=%0d OUT_W=%0d PREFIX_TIMEOUT=%0d",
             IN_W, OUT_W, PREFIX_TIMEOUT);
   end

   typedef enum logic {
      IDLE,
      PREFIXED
   } state_e;

   state_e           state_q, state_d;
   logic [P-1:0]     prefix_q, prefix_d;
   logic [OUT_W-1:0] out_q, out_d;
   logic             out_valid_q, out_valid_d;

   logic             in_ready;
   logic             accept;
   logic             timeout;
   logic [P-1:0]     prefix_in;
   logic [OUT_W-1:0] ext_word;

   assign in_ready          = !out_valid_q || bus.OutReady;
   assign accept            = bus.InValid && in_ready;

   assign bus.InReady       = in_ready;
   assign bus.OutValid      = out_valid_q;
   assign bus.Out           = out_q;
   assign bus.PrefixPending = (state_q == PREFIXED);

   // Low min(IN_W, P) immediate bits, zero-extended to the prefix width.
   assign prefix_in = P'(bus.Immediate[PW-1:0]);

   // Stand-alone extension of the incoming immediate.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      ext_word = '0;
      unique case (bus.Mode)
         2'd0:    ext_word = OUT_W'(bus.Immediate);
         2'd1:    ext_word = {{P{bus.Immediate[IN_W-1]}}, bus.Immediate};
         2'd2:    ext_word = OUT_W'(bus.Immediate) << P;
         default: ext_word = '0;  // prefix words never reach Out directly
      endcase
   end

`ifdef EXT_PREFIX_TIMEOUT_EN
   localparam int CNT_W = $clog2(PREFIX_TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign timeout = (state_q == PREFIXED) && (cnt_q == CNT_W'(PREFIX_TIMEOUT));

   // Idle-cycle counter: restarts on every prefix accept, counts only while a
   // prefix waits with no accept, and saturates at PREFIX_TIMEOUT.
   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if (state_q == PREFIXED) begin
         if (cnt_q != CNT_W'(PREFIX_TIMEOUT)) begin
            cnt_d = cnt_q + 1'b1;
         end
      end else begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Next-state and datapath: prefix FSM plus the single output register.
   always_comb begin
      state_d     = state_q;
      prefix_d    = prefix_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;

      // Normal drain; a new load below takes precedence. Out keeps its value.
      if (out_valid_q && bus.OutReady) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (bus.Mode == 2'd3) begin
            // Last prefix wins; the output register is left alone.
            state_d  = PREFIXED;
            prefix_d = prefix_in;
         end else begin
            // A pending prefix overrides the word's own Mode.
            out_d       = (state_q == PREFIXED) ? {prefix_q, bus.Immediate} : ext_word;
            out_valid_d = 1'b1;
            state_d     = IDLE;
            prefix_d    = '0;
         end
      end else if (timeout) begin
         state_d  = IDLE;
         prefix_d = '0;
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (Reset) begin
         // NOTE: all state, including the data register Out, is cleared
         // because downstream may observe Out right after reset.
         state_q     <= IDLE;
         prefix_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         prefix_q    <= prefix_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_imm_extender_pipe.sv
// -----------------------------------------------------------------------------
// tb_imm_extender_pipe
//   Directed bench for imm_extender_pipe (IN_W=8, OUT_W=16, PREFIX_TIMEOUT=15).
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   the same point, i.e. just after the edge that produced them.
// -----------------------------------------------------------------------------
module tb_imm_extender_pipe;

   localparam int IN_W  = 8;
   localparam int OUT_W = 16;

   logic CLK;
   logic Reset;

   int tests_run;
   int tests_failed;

   imm_extender_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

   imm_extender_pipe #(
      .IN_W           (IN_W),
      .OUT_W          (OUT_W),
      .PREFIX_TIMEOUT (15)
   ) dut (
      .CLK   (CLK),
      .Reset (Reset),
      .bus   (bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Advance one clock and land just after the edge.
   task automatic cycle();
      @(posedge CLK);
      #1;
   endtask

   // Present one word for exactly one edge, then drop InValid.
   task automatic send(input logic [1:0] mode, input logic [IN_W-1:0] imm);
      bus.InValid   = 1'b1;
      bus.Mode      = mode;
      bus.Immediate = imm;
      cycle();
      bus.InValid   = 1'b0;
   endtask

   task automatic test_reset();
      Reset        = 1'b1;
      bus.InValid  = 1'b1;   // reset must win over a simultaneous accept
      bus.Mode     = 2'd0;
      bus.Immediate = 8'h5A;
      bus.OutReady = 1'b1;
      cycle();
      cycle();
      bus.InValid  = 1'b0;
      Reset        = 1'b0;
      tests_run++;
      if (bus.OutValid !== 1'b0) begin
         tests_failed++; $display("FAIL reset_outvalid: got %b expected 0", bus.OutValid);
      end
      tests_run++;
      if (bus.Out !== 16'h0000) begin
         tests_failed++; $display("FAIL reset_out: got %h expected 0000", bus.Out);
      end
      tests_run++;
      if (bus.PrefixPending !== 1'b0) begin
         tests_failed++; $display("FAIL reset_pending: got %b expected 0", bus.PrefixPending);
      end
      tests_run++;
      if (bus.InReady !== 1'b1) begin
         tests_failed++; $display("FAIL reset_inready: got %b expected 1", bus.InReady);
      end
   endtask

   task automatic test_basic_modes();
      // mode, immediate, expected result
      logic [1:0]       modes [5] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
      logic [IN_W-1:0]  imms  [5] = '{8'h07, 8'h07, 8'hF7, 8'hF7, 8'hF7};
      logic [OUT_W-1:0] exps  [5] = '{16'h0007, 16'h0007, 16'h00F7, 16'hFFF7, 16'hF700};
      bus.OutReady = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(modes[i], imms[i]);
         tests_run++;
         if (bus.OutValid !== 1'b1) begin
            tests_failed++; $display("FAIL mode%0d_valid[%0d]: got %b expected 1", modes[i], i, bus.OutValid);
         end
         tests_run++;
         if (bus.Out !== exps[i]) begin
            tests_failed++; $display("FAIL mode%0d_out[%0d]: got %h expected %h", modes[i], i, bus.Out, exps[i]);
         end
      end
   endtask

   task automatic test_prefix();
      bus.OutReady = 1'b1;
      send(2'd3, 8'h12);
      tests_run++;
      if (bus.PrefixPending !== 1'b1) begin
         tests_failed++; $display("FAIL prefix_pending: got %b expected 1", bus.PrefixPending);
      end
      // the previous word drained on this edge; a prefix produces nothing
      tests_run++;
      if (bus.OutValid !== 1'b0) begin
         tests_failed++; $display("FAIL prefix_no_output: got %b expected 0", bus.OutValid);
      end
      send(2'd1, 8'h80);
      tests_run++;
      if (bus.Out !== 16'h1280 || bus.OutValid !== 1'b1) begin
         tests_failed++; $display("FAIL prefix_concat: got %h/%b expected 1280/1", bus.Out, bus.OutValid);
      end
      tests_run++;
      if (bus.PrefixPending !== 1'b0) begin
         tests_failed++; $display("FAIL prefix_consumed: got %b expected 0", bus.PrefixPending);
      end
   endtask

   task automatic test_backpressure();
      cycle();                 // drain previous result
      bus.OutReady = 1'b0;
      send(2'd0, 8'h05);
      tests_run++;
      if (bus.OutValid !== 1'b1 || bus.Out !== 16'h0005) begin
         tests_failed++; $display("FAIL bp_first: got %h/%b expected 0005/1", bus.Out, bus.OutValid);
      end
      tests_run++;
      if (bus.InReady !== 1'b0) begin
         tests_failed++; $display("FAIL bp_inready: got %b expected 0", bus.InReady);
      end
      bus.InValid   = 1'b1;
      bus.Mode      = 2'd0;
      bus.Immediate = 8'h06;
      for (int i = 0; i < 3; i++) begin
         cycle();
         tests_run++;
         if (bus.Out !== 16'h0005 || bus.OutValid !== 1'b1 || bus.InReady !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_hold[%0d]: got %h/%b/%b expected 0005/1/0", i, bus.Out, bus.OutValid, bus.InReady);
         end
      end
      bus.OutReady = 1'b1;
      cycle();
      bus.InValid = 1'b0;
      tests_run++;
      if (bus.Out !== 16'h0006 || bus.OutValid !== 1'b1) begin
         tests_failed++; $display("FAIL bp_release: got %h/%b expected 0006/1", bus.Out, bus.OutValid);
      end
      cycle();
      tests_run++;
      if (bus.OutValid !== 1'b0 || bus.Out !== 16'h0006) begin
         tests_failed++; $display("FAIL bp_no_dup: got %h/%b expected 0006/0", bus.Out, bus.OutValid);
      end
   endtask

   task automatic test_back_to_back_prefix();
      bus.OutReady = 1'b1;
      send(2'd3, 8'h11);
      send(2'd3, 8'h22);
      send(2'd0, 8'h33);
      tests_run++;
      if (bus.Out !== 16'h2233 || bus.OutValid !== 1'b1) begin
         tests_failed++; $display("FAIL last_prefix_wins: got %h/%b expected 2233/1", bus.Out, bus.OutValid);
      end
      send(2'd3, 8'h44);
      Reset = 1'b1;
      cycle();
      Reset = 1'b0;
      tests_run++;
      if (bus.PrefixPending !== 1'b0) begin
         tests_failed++; $display("FAIL reset_mid_prefix: got %b expected 0", bus.PrefixPending);
      end
      send(2'd1, 8'h80);
      tests_run++;
      if (bus.Out !== 16'hFF80) begin
         tests_failed++; $display("FAIL after_reset_sign: got %h expected FF80", bus.Out);
      end
   endtask

   task automatic test_prefix_timeout();
      bus.OutReady = 1'b1;
      send(2'd3, 8'hAB);
      repeat (15) cycle();
      // 15 idle cycles: counter just reached the limit, prefix still held
      tests_run++;
      if (bus.PrefixPending !== 1'b1) begin
         tests_failed++; $display("FAIL timeout_edge_minus1: got %b expected 1", bus.PrefixPending);
      end
      cycle();
`ifdef EXT_PREFIX_TIMEOUT_EN
      tests_run++;
      if (bus.PrefixPending !== 1'b0) begin
         tests_failed++; $display("FAIL timeout_drop: got %b expected 0", bus.PrefixPending);
      end
      send(2'd0, 8'h01);
      tests_run++;
      if (bus.Out !== 16'h0001) begin
         tests_failed++; $display("FAIL timeout_next_word: got %h expected 0001", bus.Out);
      end
`else
      tests_run++;
      if (bus.PrefixPending !== 1'b1) begin
         tests_failed++; $display("FAIL prefix_persists: got %b expected 1", bus.PrefixPending);
      end
      send(2'd0, 8'h01);
      tests_run++;
      if (bus.Out !== 16'hAB01) begin
         tests_failed++; $display("FAIL prefix_late_concat: got %h expected AB01", bus.Out);
      end
`endif
   endtask

   initial begin
      tests_run     = 0;
      tests_failed  = 0;
      Reset         = 1'b1;
      bus.InValid   = 1'b0;
      bus.Mode      = 2'd0;
      bus.Immediate = '0;
      bus.OutReady  = 1'b0;
      #1;
      test_reset();
      test_basic_modes();
      test_prefix();
      test_backpressure();
      test_back_to_back_prefix();
      test_prefix_timeout();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
